// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
// Imported by the interface, the top-level module and the bench.
package serial_sub_pkg;

  // Three-state controller encoding: IDLE=0, SHIFT=1, DONE=2
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle of the bit-serial subtractor.
// Ports carried:
//   start      - request to begin a subtraction (master -> slave)
//   a, b, bin  - minuend, subtrahend, borrow-in (master -> slave)
//   busy       - controller is not idle (slave -> master)
//   done       - one-cycle result-valid pulse (slave -> master)
//   diff, bout - a - b - bin modulo 2^WIDTH and its borrow-out (slave -> master)
interface serial_subtractor_if #(
  parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor used by the serial datapath.
// Ports:
//   x  - minuend bit
//   y  - subtrahend bit
//   bi - borrow in
//   d  - difference bit, x - y - bi modulo 2
//   bo - borrow out, set when x < y + bi
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when y beats x outright, or when they tie and a borrow is pending
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first.
// Ports:
//   clk   - single clock, all state changes on its rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of serial_subtractor_if (start/a/b/bin in,
//           busy/done/diff/bout out)
// A start seen in IDLE loads the operands and enters SHIFT; after WIDTH
// SHIFT edges the controller spends one cycle in DONE and returns to IDLE.
// diff and bout keep their final values until the next accepted start.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_next;
  logic             br_q;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic             bit_d;
  logic             bit_bo;

  full_subtractor u_fs (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q),
    .d  (bit_d),
    .bo (bit_bo)
  );

  // New difference bit enters at the MSB so that after WIDTH shifts the
  // first (LSB) result bit has walked down to position 0.
  generate
    if (WIDTH == 1) begin : g_diff_w1
      assign diff_next = bit_d;
    end else begin : g_diff_wn
      assign diff_next = {bit_d, diff_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            br_q   <= bus.bin;
            diff_q <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          diff_q <= diff_next;
          br_q   <= bit_bo;
          cnt    <= cnt + CW'(1);
          // The edge that consumes the last bit also raises done
          if (cnt == LAST_BIT) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = br_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8.
// Directed vector table, held-start sequence, mid-operation reset and a
// batch of random operations checked against an arithmetic reference.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  serial_subtractor_if #(.WIDTH(W)) sif ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  vec_t vecs[10];

  // Compare one value against its expectation and tally the result
  task automatic check_output(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Run one operation; operands are scrambled right after acceptance so any
  // dependence on the live inputs during SHIFT/DONE shows up as a bad result.
  task automatic apply_stimulus(input string name, input logic [W-1:0] ia,
                                input logic [W-1:0] ib, input logic ibin,
                                input logic [W-1:0] exp_diff,
                                input logic exp_bout, input bit full_checks);
    int edges;
    int busy_cycles;
    logic [W-1:0] got_diff;
    logic got_bout;
    @(negedge clk);
    sif.a     = ia;
    sif.b     = ib;
    sif.bin   = ibin;
    sif.start = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    sif.a     = ~ia;
    sif.b     = ~ib;
    sif.bin   = ~ibin;
    busy_cycles = int'(sif.busy);
    edges = 0;
    while (!sif.done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      busy_cycles += int'(sif.busy);
    end
    got_diff = sif.diff;
    got_bout = sif.bout;
    if (!sif.done) check_output({name, " done timeout"}, 32'(edges), 32'd8);
    check_output({name, " diff"}, 32'(got_diff), 32'(exp_diff));
    check_output({name, " bout"}, 32'(got_bout), 32'(exp_bout));
    @(posedge clk);
    #1;
    busy_cycles += int'(sif.busy);
    if (full_checks) begin
      check_output({name, " done latency"}, 32'(edges), 32'd8);
      check_output({name, " busy cycles"}, 32'(busy_cycles), 32'd9);
      check_output({name, " done one cycle"}, 32'(sif.done), 32'd0);
      check_output({name, " diff held"}, 32'(sif.diff), 32'(exp_diff));
      check_output({name, " bout held"}, 32'(sif.bout), 32'(exp_bout));
    end
  endtask

  initial begin
    int done_cycles[$];
    logic [W:0] ref_val;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rbin;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    vecs[5] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
    vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0};
    vecs[7] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1};
    vecs[8] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[9] = '{8'h01, 8'h01, 1'b1, 8'hFF, 1'b1};

    rst_n     = 1'b0;
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;
    sif.bin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset busy", 32'(sif.busy), 32'd0);
    check_output("reset done", 32'(sif.done), 32'd0);
    check_output("reset diff", 32'(sif.diff), 32'd0);
    check_output("reset bout", 32'(sif.bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                     vecs[i].exp_diff, vecs[i].exp_bout, 1'b1);
    end

    // Start held high for 30 cycles; operands garbled while busy
    @(negedge clk);
    sif.a     = 8'h80;
    sif.b     = 8'h01;
    sif.bin   = 1'b0;
    sif.start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      #1;
      if (sif.done) begin
        done_cycles.push_back(cyc);
        check_output($sformatf("held diff c%0d", cyc), 32'(sif.diff), 32'h7F);
        check_output($sformatf("held bout c%0d", cyc), 32'(sif.bout), 32'd0);
        sif.a   = 8'h80;
        sif.b   = 8'h01;
        sif.bin = 1'b0;
      end else if (sif.busy) begin
        sif.a   = W'($urandom);
        sif.b   = W'($urandom);
        sif.bin = 1'($urandom);
      end
    end
    sif.start = 1'b0;
    check_output("held pulse count", 32'(done_cycles.size()), 32'd3);
    for (int i = 1; i < done_cycles.size(); i++) begin
      check_output($sformatf("held gap %0d", i),
                   32'(done_cycles[i] - done_cycles[i-1]), 32'd10);
    end
    repeat (2) @(posedge clk);

    // Reset in the middle of SHIFT, after four bits have been processed
    @(negedge clk);
    sif.a     = 8'h3C;
    sif.b     = 8'h05;
    sif.bin   = 1'b0;
    sif.start = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_output("pre-abort busy", 32'(sif.busy), 32'd1);
    check_output("pre-abort partial diff", 32'(sif.diff), 32'h70);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort busy", 32'(sif.busy), 32'd0);
    check_output("abort done", 32'(sif.done), 32'd0);
    check_output("abort diff", 32'(sif.diff), 32'd0);
    check_output("abort bout", 32'(sif.bout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("abort no done %0d", i), 32'(sif.done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("post-reset", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b1);

    // Random operations against an exact-width arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      ref_val = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      apply_stimulus($sformatf("rand%0d", i), ra, rb, rbin, ref_val[W-1:0],
                     ref_val[W], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: the minuend, captured on the accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: the subtrahend, captured on the accepted start.
REQ-007 The block SHALL have port bin, input, 1 bit: the borrow-in, captured on the accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port diff, output, WIDTH bits: the result a - b - bin, modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit: the borrow-out, high when a < b + bin as unsigned values.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, start=1 SHALL:
- load a, b and bin into internal registers;
- clear the bit counter;
- move to SHIFT on the same edge.
REQ-014 Each SHIFT cycle SHALL process one bit, LSB first:
- d = a0 ^ b0 ^ br;
- br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-015 Each SHIFT edge SHALL:
- shift the a and b registers right;
- shift d into the MSB of the diff shift register;
- update the borrow register;
- increment the counter.
REQ-016 After WIDTH SHIFT cycles the FSM SHALL enter DONE, so done is high during the cycle following the WIDTH-th edge after the start-sampling edge.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-018 diff and bout SHALL hold their final values from DONE until the next accepted start.
REQ-019 While in SHIFT or DONE, start SHALL be ignored, and a/b/bin changes SHALL have no effect.
REQ-020 If start is held high continuously, a new operation SHALL be accepted in the first IDLE cycle after DONE.
REQ-021 done SHALL never be high for two consecutive cycles.
REQ-022 With WIDTH=1, the block SHALL complete in one SHIFT cycle with identical rules.
REQ-023 diff and bout SHALL equal the low WIDTH bits and the borrow of the exact unsigned difference; no saturation.

Reset
REQ-024 While rst_n=0, regardless of clk, the block SHALL force:
- state to IDLE;
- busy=0, done=0, diff=0, bout=0;
- all internal registers and the counter to 0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation, produce no done pulse and discard partial results.
REQ-026 The first start after rst_n deasserts SHALL be accepted normally on the next rising edge.

Structure
REQ-027 A shared package serial_sub_pkg SHALL hold:
- the state encoding constants (IDLE=0, SHIFT=1, DONE=2);
- DEFAULT_WIDTH=8.
REQ-028 The counter SHALL be $clog2(WIDTH+1) bits wide.
REQ-029 The bit-level arithmetic SHALL be a sub-module full_subtractor (inputs x, y, bi; outputs d, bo), instantiated once.
REQ-030 Only the borrow register and the FSM SHALL be sequential outside the shift registers.

Verification (WIDTH=8)
REQ-031 a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0; done exactly 8 edges after the start edge; busy high for 9 cycles.
REQ-032 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1.
REQ-033 a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1; a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0.
REQ-034 start held high for 30 cycles with a=0x80, b=0x01 -> done pulses separated by 10 cycles, each with diff=0x7F, bout=0; operand changes mid-SHIFT ignored.
REQ-035 rst_n pulsed low at SHIFT bit 4 -> outputs 0 immediately, no done; the following a=0x10, b=0x20 yields diff=0xF0, bout=1.
REQ-036 1000 random a/b/bin triples with back-to-back starts -> diff and bout match a reference model of a - b - bin on every done.
